// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// fill count, sticky overflow/underflow flags and optional first-word-fall-through read.
module fifo_sync_flags #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AF_LEVEL   = 6,
  parameter int unsigned AE_LEVEL   = 2,
  parameter bit          FWFT       = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cs,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_empty,
  output logic                          almost_full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          clr_err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  logic                  wr_acc;
  logic                  rd_acc;
  logic [PTR_W-1:0]      wr_ptr_nxt;
  logic [PTR_W-1:0]      rd_ptr_nxt;
  logic [CNT_W-1:0]      count_nxt;
  logic                  overflow_nxt;
  logic                  underflow_nxt;
  logic [DATA_WIDTH-1:0] data_out_nxt;

  // Accept decisions, next pointers/count/error flags and next read data
  always_comb begin
    wr_acc        = 1'b0;
    rd_acc        = 1'b0;
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    count_nxt     = count;
    overflow_nxt  = overflow;
    underflow_nxt = underflow;
    data_out_nxt  = data_out;

    if (rst) begin
      wr_ptr_nxt    = '0;
      rd_ptr_nxt    = '0;
      count_nxt     = '0;
      overflow_nxt  = 1'b0;
      underflow_nxt = 1'b0;
      data_out_nxt  = '0;
    end else begin
      // full/empty reflect the pre-edge count, so a simultaneous op at a limit
      // only lets the side that can make progress through
      wr_acc = cs & wr_en & ~full;
      rd_acc = cs & rd_en & ~empty;

      if (wr_acc) wr_ptr_nxt = wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr_nxt = rd_ptr + PTR_W'(1);
      count_nxt = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);

      // set beats clear when both happen in the same cycle
      if (clr_err) begin
        overflow_nxt  = 1'b0;
        underflow_nxt = 1'b0;
      end
      if (cs & wr_en & full)  overflow_nxt  = 1'b1;
      if (cs & rd_en & empty) underflow_nxt = 1'b1;

      if (FWFT) begin
        // show the head word; bypass the write data when it lands on the head slot
        if (count_nxt == '0)
          data_out_nxt = '0;
        else if (wr_acc && (rd_ptr_nxt == wr_ptr))
          data_out_nxt = data_in;
        else
          data_out_nxt = mem[rd_ptr_nxt];
      end else begin
        if (rd_acc) data_out_nxt = mem[rd_ptr];
      end
    end
  end

  // Storage array; never reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  // Pointers, count, registered flags, errors and read data
  always_ff @(posedge clk) begin
    wr_ptr       <= wr_ptr_nxt;
    rd_ptr       <= rd_ptr_nxt;
    count        <= count_nxt;
    overflow     <= overflow_nxt;
    underflow    <= underflow_nxt;
    data_out     <= data_out_nxt;
    empty        <= (count_nxt == '0);
    full         <= (count_nxt == CNT_W'(FIFO_DEPTH));
    almost_empty <= (count_nxt <= CNT_W'(AE_LEVEL));
    almost_full  <= (count_nxt >= CNT_W'(AF_LEVEL));
  end

endmodule
